shot_clock_ctrl: RTL and testbench

SHOT_CLOCK_CTRL -- requirements
Module: shot_clock_ctrl

---
 rtl/shot_clock_ctrl_pkg.sv | 45 ++++
 rtl/edge_sync_rise.sv | 41 ++++
 rtl/shot_clock_ctrl.sv | 142 ++++++++++++++
 tb/tb_shot_clock_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shot_clock_ctrl_pkg.sv
// Shared definitions for the shot-clock controller: FSM state encoding,
// BCD digit width and small BCD helpers used by the top level.
`timescale 1ns/1ps
package shot_clock_ctrl_pkg;

  // Width of one BCD digit.
  localparam int unsigned BCD_W = 4;

  // Controller states; the encoding is fixed so debug taps read consistently.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Remaining seconds as two BCD digits.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_sec_t;

  // Convert a binary seconds value (0..99) to two BCD digits.
  function automatic bcd_sec_t to_bcd(input int unsigned v);
    bcd_sec_t r;
    r.tens = BCD_W'((v / 10) % 10);
    r.ones = BCD_W'(v % 10);
    return r;
  endfunction

  // Decrement a BCD seconds value by one; ones digit 0 borrows from tens.
  // Callers never pass 00, so the tens digit cannot underflow.
  function automatic bcd_sec_t bcd_dec(input bcd_sec_t s);
    bcd_sec_t r;
    if (s.ones == '0) begin
      r.ones = BCD_W'(9);
      r.tens = s.tens - BCD_W'(1);
    end else begin
      r.ones = s.ones - BCD_W'(1);
      r.tens = s.tens;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// rise pulses for one clk_in cycle, three cycles after din rises.
`timescale 1ns/1ps
module edge_sync_rise
  import shot_clock_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic rise_d;

  // Edge condition on the synchronized signal.
  always_comb begin
    rise_d = sync2_q & ~prev_q;
  end

  // Synchronizer chain, previous-value flop and registered pulse.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: counts down a BCD seconds display in quarter-second
// steps taken from a synchronized 4 Hz input, with pause/start and two
// reload values. Optional buzzer window enabled by SHOT_CLOCK_BUZZER_EN;
// without that macro buzzer is tied low and its counter is not built.
`timescale 1ns/1ps
module shot_clock_ctrl
  import shot_clock_ctrl_pkg::*;
#(
  parameter int unsigned RELOAD_A    = 24,
  parameter int unsigned RELOAD_B    = 14,
  parameter int unsigned BUZZ_QTICKS = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_4hz,
  input  logic             start,
  input  logic             pause,
  input  logic             reload_a,
  input  logic             reload_b,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             expired,
  output logic             buzzer
);

  localparam bcd_sec_t RELOAD_A_BCD = to_bcd(RELOAD_A);
  localparam bcd_sec_t RELOAD_B_BCD = to_bcd(RELOAD_B);

  logic     qtick;
  state_e   state_q,   state_d;
  bcd_sec_t secs_q,    secs_d;
  logic [1:0] qcnt_q,  qcnt_d;
  logic     running_q, running_d;
  logic     expired_q, expired_d;

  edge_sync_rise u_qtick_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (clk_4hz),
    .rise   (qtick)
  );

  // Next-state logic: reloads dominate, then pause, then start; quarter
  // ticks only move the count while RUN and no command changed the state.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    qcnt_d  = qcnt_q;
    if (reload_a) begin
      secs_d  = RELOAD_A_BCD;
      qcnt_d  = 2'd0;
      state_d = ST_IDLE;
    end else if (reload_b) begin
      secs_d  = RELOAD_B_BCD;
      qcnt_d  = 2'd0;
      state_d = ST_IDLE;
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else begin
      if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
        state_d = ST_RUN;
      end
      if (qtick && (state_q == ST_RUN)) begin
        qcnt_d = qcnt_q + 2'd1;
        if (qcnt_q == 2'd3) begin
          secs_d = bcd_dec(secs_q);
          // Display reaches 00 in the same cycle the FSM enters EXPIRED.
          if ((secs_q.tens == '0) && (secs_q.ones == BCD_W'(1))) begin
            state_d = ST_EXPIRED;
          end
        end
      end
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      secs_q    <= RELOAD_A_BCD;
      qcnt_q    <= 2'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      qcnt_q    <= qcnt_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

`ifdef SHOT_CLOCK_BUZZER_EN
  localparam int unsigned BCNT_W = $clog2(BUZZ_QTICKS + 1);

  logic              buzz_q, buzz_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  // Buzzer window: set on entry to EXPIRED, counts qticks in any state,
  // drops after BUZZ_QTICKS of them, cleared by either reload.
  always_comb begin
    buzz_d = buzz_q;
    bcnt_d = bcnt_q;
    if (reload_a || reload_b) begin
      buzz_d = 1'b0;
      bcnt_d = '0;
    end else if ((state_q != ST_EXPIRED) && (state_d == ST_EXPIRED)) begin
      buzz_d = 1'b1;
      bcnt_d = '0;
    end else if (qtick && buzz_q) begin
      bcnt_d = bcnt_q + BCNT_W'(1);
      if (bcnt_q == BCNT_W'(BUZZ_QTICKS - 1)) begin
        buzz_d = 1'b0;
      end
    end
  end

  // Buzzer flag and quarter-tick counter.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      buzz_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      buzz_q <= buzz_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign buzzer = buzz_q;
`else
  assign buzzer = 1'b0;
`endif

  assign sec_tens = secs_q.tens;
  assign sec_ones = secs_q.ones;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Scoreboard bench for shot_clock_ctrl: a behavioural model pushes the
// expected display/status word whenever stimulus is driven, and the word is
// popped and compared once the DUT has had time to respond.
`timescale 1ns/1ps
module tb_shot_clock_ctrl;

  logic       clk_in   = 1'b0;
  logic       rst      = 1'b0;
  logic       clk_4hz  = 1'b0;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       reload_a = 1'b0;
  logic       reload_b = 1'b0;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       expired;
  logic       buzzer;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: seconds in binary, quarter count, state, buzzer.
  int m_secs  = 24;
  int m_q     = 0;
  int m_state = 0;   // 0 idle, 1 run, 2 pause, 3 expired
  int m_buzz  = 0;
  int m_bcnt  = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #10 clk_in = ~clk_in;

  shot_clock_ctrl dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .clk_4hz  (clk_4hz),
    .start    (start),
    .pause    (pause),
    .reload_a (reload_a),
    .reload_b (reload_b),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .expired  (expired),
    .buzzer   (buzzer)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk  %s ok val=%0h", tag, got);
    end
  endtask

  function automatic logic [10:0] model_obs();
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
    t = 4'(m_secs / 10);
    o = 4'(m_secs % 10);
`ifdef SHOT_CLOCK_BUZZER_EN
    b = (m_buzz != 0);
`else
    b = 1'b0;
`endif
    return {t, o, (m_state == 1), (m_state == 3), b};
  endfunction

  task automatic push_exp(input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = model_obs();
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    sb_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, {21'd0, sec_tens, sec_ones, running, expired, buzzer}, {21'd0, e.exp});
    end
  endtask

  task automatic model_qtick();
    if (m_state == 1) begin
      m_q = (m_q + 1) % 4;
      if (m_q == 0) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state = 3;
          m_buzz  = 1;
          m_bcnt  = 0;
        end
      end
    end else if (m_buzz != 0) begin
      m_bcnt = m_bcnt + 1;
      if (m_bcnt == 8) m_buzz = 0;
    end
  endtask

  task automatic model_cmd(input bit a, input bit b, input bit p, input bit s);
    if (a) begin
      m_secs = 24; m_q = 0; m_buzz = 0; m_bcnt = 0; m_state = 0;
    end else if (b) begin
      m_secs = 14; m_q = 0; m_buzz = 0; m_bcnt = 0; m_state = 0;
    end else if (p && m_state == 1) begin
      m_state = 2;
    end else if (s && (m_state == 0 || m_state == 2)) begin
      m_state = 1;
    end
  endtask

  // One rising edge of the 4 Hz input, then let it go low again.
  task automatic qedge(input string tag);
    @(negedge clk_in);
    clk_4hz = 1'b1;
    model_qtick();
    push_exp(tag);
    repeat (6) @(negedge clk_in);
    pop_cmp();
    clk_4hz = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  // Same as qedge but also measures cycles from input rise to display change.
  task automatic qedge_lat(input string tag);
    logic [3:0] prev;
    int         lat;
    @(negedge clk_in);
    prev    = sec_ones;
    clk_4hz = 1'b1;
    model_qtick();
    push_exp(tag);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      if (sec_ones !== prev) begin
        lat = c;
        break;
      end
    end
    check_val("qtick_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk_in);
    pop_cmp();
    clk_4hz = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic cmd(input bit a, input bit b, input bit p, input bit s, input string tag);
    @(negedge clk_in);
    reload_a = a; reload_b = b; pause = p; start = s;
    model_cmd(a, b, p, s);
    @(negedge clk_in);
    reload_a = 1'b0; reload_b = 1'b0; pause = 1'b0; start = 1'b0;
    push_exp(tag);
    pop_cmp();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    m_secs = 24; m_q = 0; m_state = 0; m_buzz = 0; m_bcnt = 0;
    #1;
    push_exp("rst_async");
    pop_cmp();
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    push_exp("rst_release");
    pop_cmp();
  endtask

  // Overall time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Full countdown from 24 to expiry, then the buzzer window.
    cmd(0, 0, 0, 1, "start");
    for (int i = 1; i <= 96; i++) qedge($sformatf("run24_q%0d", i));
    for (int i = 1; i <= 8; i++) qedge($sformatf("buzz_q%0d", i));
    cmd(0, 1, 0, 0, "reload_b");

    // Pause holds the quarter counter.
    cmd(1, 0, 0, 0, "reload_a");
    cmd(0, 0, 0, 1, "start_b");
    for (int i = 1; i <= 6; i++) qedge($sformatf("pre_pause_q%0d", i));
    cmd(0, 0, 1, 0, "pause");
    for (int i = 1; i <= 20; i++) qedge($sformatf("paused_q%0d", i));
    cmd(0, 0, 0, 1, "resume");
    for (int i = 1; i <= 2; i++) qedge($sformatf("resumed_q%0d", i));

    // Command priority and ignored commands.
    cmd(0, 0, 1, 1, "pause_beats_start");
    cmd(0, 0, 0, 1, "start_from_pause");
    cmd(0, 0, 0, 1, "start_in_run_ignored");

    // Run down to 10 and hit reload_a together with start.
    for (int i = 0; i < 200 && m_secs != 10; i++) qedge($sformatf("to10_q%0d", i));
    cmd(1, 0, 0, 1, "reload_a_with_start");
    cmd(0, 0, 1, 0, "pause_idle_ignored");

    // Quarter-tick latency on a wrapping tick.
    cmd(0, 0, 0, 1, "start_c");
    for (int i = 1; i <= 3; i++) qedge($sformatf("lat_pre_q%0d", i));
    qedge_lat("lat_wrap");

    // Reset in the middle of the buzzer window.
    cmd(0, 1, 0, 0, "reload_b_d");
    cmd(0, 0, 0, 1, "start_d");
    for (int i = 0; i < 100 && m_state != 3; i++) qedge($sformatf("to0_q%0d", i));
    for (int i = 1; i <= 2; i++) qedge($sformatf("midbuzz_q%0d", i));
    do_reset();
    for (int i = 1; i <= 4; i++) qedge($sformatf("post_rst_q%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
